// File: rtl/scu_pkg.sv
// Shared SCU decode definitions: sizes, opcodes, instruction field positions and
// opcode-class helpers used by the decode stage and its scoreboard.
package scu_pkg;

    localparam int unsigned NREG = 64;
    localparam int unsigned AW   = 6;
    localparam int unsigned DW   = 32;
    localparam int unsigned SCW  = 16;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 28;
    localparam int unsigned RD_HI  = 27;
    localparam int unsigned RD_LO  = 22;
    localparam int unsigned RS1_HI = 21;
    localparam int unsigned RS1_LO = 16;
    localparam int unsigned RS2_HI = 15;
    localparam int unsigned RS2_LO = 10;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    typedef struct packed {
        logic [3:0]    opcode;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [DW-1:0] imm;
    } dec_fields_t;

    function automatic dec_fields_t decode_fields(input logic [DW-1:0] instr);
        dec_fields_t f;
        f.opcode = instr[OPC_HI:OPC_LO];
        f.rd     = instr[RD_HI:RD_LO];
        f.rs1    = instr[RS1_HI:RS1_LO];
        f.rs2    = instr[RS2_HI:RS2_LO];
        f.imm    = {{(DW - 16){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
        return f;
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        case (op)
            OP_SVPC, OP_LD, OP_ADD, OP_INC, OP_NEG, OP_SUB: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [3:0] op);
        case (op)
            OP_LD, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
            OP_J, OP_BRZ, OP_JM, OP_BRN: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [3:0] op);
        case (op)
            OP_ST, OP_ADD, OP_SUB: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode, decode-to-execute, writeback and flush signals of the decode stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if;
    import scu_pkg::*;

    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [DW-1:0] if_pc;
    logic          if_ready;

    logic          id_valid;
    logic          id_ready;
    logic [3:0]    id_opcode;
    logic [AW-1:0] id_rd;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_wrt;
    logic [DW-1:0] id_imm;
    logic [DW-1:0] id_pc;

    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          flush;

    modport slave (
        input  if_valid, if_instr, if_pc, id_ready, wb_valid, wb_rd, flush,
        output if_ready, id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_wrt, id_imm, id_pc
    );

    modport master (
        output if_valid, if_instr, if_pc, id_ready, wb_valid, wb_rd, flush,
        input  if_ready, id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_wrt, id_imm, id_pc
    );

endinterface

// File: rtl/decode_scoreboard.sv
// Busy-bit scoreboard: one bit per register with a write in flight, plus three
// lookup ports that already see a same-cycle writeback as retired.
module decode_scoreboard
    import scu_pkg::*;
#(
    parameter int unsigned NREG = scu_pkg::NREG,
    parameter int unsigned AW   = scu_pkg::AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_set_en,
    input  logic [AW-1:0]       i_set_idx,
    input  logic                i_clr_en,
    input  logic [AW-1:0]       i_clr_idx,
    input  logic [2:0][AW-1:0]  i_rd_idx,
    output logic [2:0]          o_busy_eff
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_d;

    // Set is applied after clear: a newly issued write to a retiring register stays pending.
    always_comb begin
        w_busy_d = r_busy;
        if (i_clr_en) w_busy_d[i_clr_idx] = 1'b0;
        if (i_set_en) w_busy_d[i_set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_lookup
        assign o_busy_eff[g] = r_busy[i_rd_idx[g]] & ~(i_clr_en & (i_clr_idx == i_rd_idx[g]));
    end

endmodule

// File: rtl/decode_stage.sv
// SCU instruction-decode stage: one-deep holding register, field split, and
// scoreboard-based RAW/WAW interlock in front of the register file and execute.
module decode_stage
    import scu_pkg::*;
#(
    parameter int unsigned NREG = scu_pkg::NREG,
    parameter int unsigned AW   = scu_pkg::AW,
    parameter int unsigned DW   = scu_pkg::DW,
    parameter int unsigned SCW  = scu_pkg::SCW
) (
    input  logic            clk,
    input  logic            rst_n,
    decode_stage_if.slave   dec_bus,
    output logic [SCW-1:0]  stall_cycles
);

    logic          r_d_valid;
    logic [DW-1:0] r_d_instr;
    logic [DW-1:0] r_d_pc;
    logic [SCW-1:0] r_stall;

    dec_fields_t w_dec;
    logic        w_reads_rs1;
    logic        w_reads_rs2;
    logic        w_wrt;
    logic [2:0]  w_busy_eff;
    logic        w_hazard;
    logic        w_id_valid;
    logic        w_fire;
    logic        w_if_ready;
    logic        w_load;

    assign w_dec       = decode_fields(r_d_instr);
    assign w_reads_rs1 = reads_rs1(w_dec.opcode);
    assign w_reads_rs2 = reads_rs2(w_dec.opcode);
    assign w_wrt       = r_d_valid & writes_rd(w_dec.opcode);

    decode_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_fire & w_wrt),
        .i_set_idx  (w_dec.rd),
        .i_clr_en   (dec_bus.wb_valid),
        .i_clr_idx  (dec_bus.wb_rd),
        .i_rd_idx   ({w_dec.rd, w_dec.rs2, w_dec.rs1}),
        .o_busy_eff (w_busy_eff)
    );

    // busy_eff order: [0]=rs1, [1]=rs2, [2]=rd (WAW)
    assign w_hazard   = r_d_valid & ((w_reads_rs1 & w_busy_eff[0]) |
                                     (w_reads_rs2 & w_busy_eff[1]) |
                                     (w_wrt & w_busy_eff[2]));
    assign w_id_valid = r_d_valid & ~w_hazard & ~dec_bus.flush;
    assign w_fire     = w_id_valid & dec_bus.id_ready;
    assign w_if_ready = ~r_d_valid | w_fire | dec_bus.flush;
    assign w_load     = dec_bus.if_valid & w_if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid <= 1'b0;
            r_d_instr <= '0;
            r_d_pc    <= '0;
        end else if (w_load) begin
            r_d_valid <= 1'b1;
            r_d_instr <= dec_bus.if_instr;
            r_d_pc    <= dec_bus.if_pc;
        end else if (w_fire || dec_bus.flush) begin
            r_d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_hazard && !dec_bus.flush && !(&r_stall)) begin
            r_stall <= r_stall + SCW'(1);
        end
    end

    assign dec_bus.if_ready  = w_if_ready;
    assign dec_bus.id_valid  = w_id_valid;
    assign dec_bus.id_opcode = w_dec.opcode;
    assign dec_bus.id_rd     = w_dec.rd;
    assign dec_bus.id_rs1    = w_dec.rs1;
    assign dec_bus.id_rs2    = w_dec.rs2;
    assign dec_bus.id_wrt    = w_wrt;
    assign dec_bus.id_imm    = w_dec.imm;
    assign dec_bus.id_pc     = r_d_pc;
    assign stall_cycles      = r_stall;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of decode vectors plus hand-written
// hazard, backpressure and flush sequences. Inputs driven and outputs sampled on negedge.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] stall_cycles;
    int          n_checks;
    int          n_errors;
    int          exp_stall;

    decode_stage_if u_if ();

    decode_stage u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_bus      (u_if),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  opc;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic        wrt;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc);
        u_if.if_valid = 1'b1;
        u_if.if_instr = instr;
        u_if.if_pc    = pc;
        tick();
        u_if.if_valid = 1'b0;
    endtask

    task automatic retire(input logic [5:0] rd);
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = rd;
        tick();
        u_if.wb_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_stall = 0;
        rst_n         = 1'b0;
        u_if.if_valid = 1'b0;
        u_if.if_instr = '0;
        u_if.if_pc    = '0;
        u_if.id_ready = 1'b1;
        u_if.wb_valid = 1'b0;
        u_if.wb_rd    = '0;
        u_if.flush    = 1'b0;

        vecs[0] = '{32'h4142_0C00, 32'h0000_0100, 4'h4, 6'd5,  6'd2,  6'd3,  1'b1, 32'h0000_0C00};
        vecs[1] = '{32'hE044_8005, 32'h0000_0104, 4'hE, 6'd1,  6'd4,  6'd32, 1'b1, 32'hFFFF_8005};
        vecs[2] = '{32'h3286_1C03, 32'h0000_0108, 4'h3, 6'd10, 6'd6,  6'd7,  1'b0, 32'h0000_1C03};
        vecs[3] = '{32'h0FFF_FFFF, 32'h0000_010C, 4'h0, 6'd63, 6'd63, 6'd63, 1'b0, 32'hFFFF_FFFF};
        vecs[4] = '{32'hC123_4567, 32'h0000_0110, 4'hC, 6'd4,  6'd35, 6'd17, 1'b0, 32'h0000_4567};
        vecs[5] = '{32'hFFC0_0000, 32'h0000_0114, 4'hF, 6'd63, 6'd0,  6'd0,  1'b1, 32'h0000_0000};

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset if_ready", 32'(u_if.if_ready), 32'd1);
        chk("reset id_valid", 32'(u_if.id_valid), 32'd0);
        chk("reset id_wrt", 32'(u_if.id_wrt), 32'd0);
        chk("reset stall", 32'(stall_cycles), 32'd0);

        // Table: each vector decoded one cycle after loading, with an empty scoreboard.
        for (int i = 0; i < 6; i++) begin
            load(vecs[i].instr, vecs[i].pc);
            chk($sformatf("v%0d id_valid", i), 32'(u_if.id_valid), 32'd1);
            chk($sformatf("v%0d opcode", i), 32'(u_if.id_opcode), 32'(vecs[i].opc));
            chk($sformatf("v%0d rd", i), 32'(u_if.id_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d rs1", i), 32'(u_if.id_rs1), 32'(vecs[i].rs1));
            chk($sformatf("v%0d rs2", i), 32'(u_if.id_rs2), 32'(vecs[i].rs2));
            chk($sformatf("v%0d wrt", i), 32'(u_if.id_wrt), 32'(vecs[i].wrt));
            chk($sformatf("v%0d imm", i), u_if.id_imm, vecs[i].imm);
            chk($sformatf("v%0d pc", i), u_if.id_pc, vecs[i].pc);
            tick();
            chk($sformatf("v%0d drained", i), 32'(u_if.id_valid), 32'd0);
            if (vecs[i].wrt) retire(vecs[i].rd);
        end
        chk("table stall", 32'(stall_cycles), 32'(exp_stall));

        // RAW: ADD r5,r2,r3 then SUB r7,r5,r3; SUB waits for r5's writeback.
        u_if.if_valid = 1'b1;
        u_if.if_instr = 32'h4142_0C00;
        u_if.if_pc    = 32'h0000_0200;
        tick();
        chk("raw add valid", 32'(u_if.id_valid), 32'd1);
        u_if.if_instr = 32'h71C5_0C00;
        u_if.if_pc    = 32'h0000_0204;
        tick();
        u_if.if_valid = 1'b0;
        chk("raw sub stalled", 32'(u_if.id_valid), 32'd0);
        chk("raw if_ready", 32'(u_if.if_ready), 32'd0);
        repeat (3) tick();
        exp_stall += 3;
        chk("raw still stalled", 32'(u_if.id_valid), 32'd0);
        chk("raw stall count", 32'(stall_cycles), 32'(exp_stall));
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 6'd5;
        #1;
        chk("raw wb bypass", 32'(u_if.id_valid), 32'd1);
        chk("raw sub rs1", 32'(u_if.id_rs1), 32'd5);
        tick();
        u_if.wb_valid = 1'b0;
        chk("raw sub fired", 32'(u_if.id_valid), 32'd0);
        chk("raw stall held", 32'(stall_cycles), 32'(exp_stall));
        retire(6'd7);

        // WAW + set/clear collision on r9.
        load(32'h5241_0000, 32'h0000_0300);
        chk("waw inc1 valid", 32'(u_if.id_valid), 32'd1);
        tick();
        load(32'h5241_0000, 32'h0000_0304);
        chk("waw inc2 stalled", 32'(u_if.id_valid), 32'd0);
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 6'd9;
        #1;
        chk("waw inc2 bypass", 32'(u_if.id_valid), 32'd1);
        tick();
        u_if.wb_valid = 1'b0;
        load(32'h4289_0000, 32'h0000_0308);
        chk("waw r9 still busy", 32'(u_if.id_valid), 32'd0);
        tick();
        exp_stall += 1;
        chk("waw stall count", 32'(stall_cycles), 32'(exp_stall));
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 6'd9;
        #1;
        chk("waw add released", 32'(u_if.id_valid), 32'd1);
        tick();
        u_if.wb_valid = 1'b0;
        retire(6'd10);

        // Backpressure: held instruction and its fields stay put while execute refuses.
        u_if.id_ready = 1'b0;
        load(32'h3286_1C03, 32'h0000_0400);
        u_if.if_valid = 1'b1;
        u_if.if_instr = 32'h0FFF_FFFF;
        u_if.if_pc    = 32'h0000_0404;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("bp%0d if_ready", c), 32'(u_if.if_ready), 32'd0);
            chk($sformatf("bp%0d id_valid", c), 32'(u_if.id_valid), 32'd1);
            chk($sformatf("bp%0d rs1", c), 32'(u_if.id_rs1), 32'd6);
            chk($sformatf("bp%0d rs2", c), 32'(u_if.id_rs2), 32'd7);
            chk($sformatf("bp%0d pc", c), u_if.id_pc, 32'h0000_0400);
            tick();
        end
        u_if.id_ready = 1'b1;
        #1;
        chk("bp release if_ready", 32'(u_if.if_ready), 32'd1);
        tick();
        u_if.if_valid = 1'b0;
        chk("bp next loaded pc", u_if.id_pc, 32'h0000_0404);
        tick();
        chk("bp stall unchanged", 32'(stall_cycles), 32'(exp_stall));

        // Flush: stalled BRZ on busy r12 is discarded; r12 stays busy.
        load(32'h4300_0000, 32'h0000_0500);
        tick();
        load(32'h900C_0000, 32'h0000_0504);
        chk("flush brz stalled", 32'(u_if.id_valid), 32'd0);
        tick();
        exp_stall += 1;
        chk("flush pre stall", 32'(stall_cycles), 32'(exp_stall));
        u_if.flush = 1'b1;
        #1;
        chk("flush id_valid", 32'(u_if.id_valid), 32'd0);
        chk("flush if_ready", 32'(u_if.if_ready), 32'd1);
        tick();
        u_if.flush = 1'b0;
        #1;
        chk("flush emptied", 32'(u_if.if_ready), 32'd1);
        chk("flush stall frozen", 32'(stall_cycles), 32'(exp_stall));
        load(32'h434C_0000, 32'h0000_0508);
        chk("flush r12 still busy", 32'(u_if.id_valid), 32'd0);
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 6'd12;
        #1;
        chk("flush r12 released", 32'(u_if.id_valid), 32'd1);
        tick();
        u_if.wb_valid = 1'b0;
        retire(6'd13);
        chk("final stall", 32'(stall_cycles), 32'(exp_stall));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
